// File: rtl/cmp_pkg.sv
// Shared constants for the compare arbiter: flag bit positions, FSM encoding, flag type.
package cmp_pkg;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef logic [2:0] flag_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the control units (master) and the compare arbiter (slave).
interface cmp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 8
);
  import cmp_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_signed;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  flag_t             rsp_flag;

  modport master (
    output req_valid, req_a, req_b, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_flag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_flag
  );

endinterface

// File: rtl/cmp_core.sv
// Combinational magnitude comparator; signed mode flips the sign bit so one unsigned compare serves both.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_is_signed,
  output flag_t        o_flag
);

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;

  // Offset-binary mapping: negative values sort below positive ones.
  assign w_a = {i_a[W-1] ^ i_is_signed, i_a[W-2:0]};
  assign w_b = {i_b[W-1] ^ i_is_signed, i_b[W-2:0]};

  always_comb begin
    o_flag = '0;
    if (w_a == w_b)     o_flag[FLAG_EQ] = 1'b1;
    else if (w_a > w_b) o_flag[FLAG_GT] = 1'b1;
    else                o_flag[FLAG_LT] = 1'b1;
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one comparator among NREQ requesters, result returned over valid/ready.
//   state | meaning
//   IDLE  | no response held
//   HOLD  | rsp_valid=1, response registers frozen until rsp_ready
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 8
) (
  input logic           clk,
  input logic           rst,
  cmp_arbiter_if.slave  bus
);

  logic [0:0]      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_rsp_id;
  flag_t           r_rsp_flag;

  logic            w_accept;
  logic            w_any;
  int              w_idx;
  logic [IDW-1:0]  w_grant_idx;
  logic [NREQ-1:0] w_grant;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_sel_signed;
  flag_t           w_flag;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    w_any       = 1'b0;
    w_idx       = 0;
    w_grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any       = 1'b1;
        w_grant_idx = IDW'(w_idx);
      end
    end
  end

  assign w_accept = !rst && ((r_state == IDLE) || bus.rsp_ready);
  assign w_grant  = (w_accept && w_any) ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;

  assign w_sel_a      = bus.req_a[int'(w_grant_idx)*W +: W];
  assign w_sel_b      = bus.req_b[int'(w_grant_idx)*W +: W];
  assign w_sel_signed = bus.req_signed[w_grant_idx];

  cmp_core #(.W(W)) u_core (
    .i_a         (w_sel_a),
    .i_b         (w_sel_b),
    .i_is_signed (w_sel_signed),
    .o_flag      (w_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_rsp_id   <= '0;
      r_rsp_flag <= '0;
    end else if (w_accept && w_any) begin
      r_state    <= HOLD;
      r_rsp_id   <= w_grant_idx;
      r_rsp_flag <= w_flag;
      r_rr_ptr   <= (int'(w_grant_idx) == NREQ-1) ? '0 : IDW'(int'(w_grant_idx) + 1);
    end else if (r_state == HOLD && bus.rsp_ready) begin
      r_state <= IDLE;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = (r_state == HOLD);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_flag  = r_rsp_flag;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, compare modes, round-robin order, backpressure, wrap, reset in HOLD.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  cmp_arbiter_if #(.NREQ(4), .IDW(2), .W(8)) bus ();

  cmp_arbiter #(.NREQ(4), .IDW(2), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_signed[i]   = s;
  endtask

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_a = '0; bus.req_b = '0; bus.req_signed = '0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      $display("FAIL reset_no_grant: req_ready=%b expected 0000", bus.req_ready); fails++;
    end
    tick();
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_flag !== 3'b000) begin
      $display("FAIL reset_outputs: valid=%b id=%0d flag=%b expected 0/0/000",
               bus.rsp_valid, bus.rsp_id, bus.rsp_flag); fails++;
    end
    bus.req_valid = '0;
    rst = 1'b0;
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      $display("FAIL reset_idle: valid=%b req_ready=%b expected 0/0000", bus.rsp_valid, bus.req_ready); fails++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_op(0, 8'h05, 8'h09, 1'b0);
    bus.req_valid = 4'b0001;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      $display("FAIL single_grant: req_ready=%b expected 0001", bus.req_ready); fails++;
    end
    tick();
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_flag !== 3'b100) begin
      $display("FAIL single_rsp: valid=%b id=%0d flag=%b expected 1/0/100",
               bus.rsp_valid, bus.rsp_id, bus.rsp_flag); fails++;
    end
    bus.rsp_ready = 1'b1;
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_flag !== 3'b100 || bus.rsp_id !== 2'd0) begin
      $display("FAIL single_retire: valid=%b id=%0d flag=%b expected 0/0/100",
               bus.rsp_valid, bus.rsp_id, bus.rsp_flag); fails++;
    end
  endtask

  task automatic test_signed();
    logic [7:0] a_v [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [7:0] b_v [3] = '{8'h01, 8'h01, 8'h80};
    logic       s_v [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] f_v [3] = '{3'b100, 3'b010, 3'b001};
    apply_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      set_op(1, a_v[i], b_v[i], s_v[i]);
      #1;
      tests++;
      if (bus.req_ready !== 4'b0010) begin
        $display("FAIL signed_grant[%0d]: req_ready=%b expected 0010", i, bus.req_ready); fails++;
      end
      tick();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_flag !== f_v[i]) begin
        $display("FAIL signed_flag[%0d]: valid=%b id=%0d flag=%b expected 1/1/%b",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_flag, f_v[i]); fails++;
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] f_v [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset();
    set_op(0, 8'h01, 8'h02, 1'b0);
    set_op(1, 8'h03, 8'h03, 1'b0);
    set_op(2, 8'h09, 8'h04, 1'b0);
    set_op(3, 8'h80, 8'h7F, 1'b1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (bus.req_ready !== (4'b0001 << (k % 4))) begin
        $display("FAIL rr_grant[%0d]: req_ready=%b expected %b", k, bus.req_ready, 4'b0001 << (k % 4)); fails++;
      end
      tick();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4) || bus.rsp_flag !== f_v[k % 4]) begin
        $display("FAIL rr_rsp[%0d]: valid=%b id=%0d flag=%b expected 1/%0d/%b",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_flag, k % 4, f_v[k % 4]); fails++;
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_op(0, 8'h10, 8'h20, 1'b0);
    set_op(2, 8'h30, 8'h20, 1'b0);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_flag !== 3'b100 || bus.req_ready !== 4'b0000) begin
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d flag=%b req_ready=%b expected 1/0/100/0000",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_flag, bus.req_ready); fails++;
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      $display("FAIL bp_release_grant: req_ready=%b expected 0100", bus.req_ready); fails++;
    end
    tick();
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_flag !== 3'b010) begin
      $display("FAIL bp_release_rsp: valid=%b id=%0d flag=%b expected 1/2/010",
               bus.rsp_valid, bus.rsp_id, bus.rsp_flag); fails++;
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] g_v [3] = '{4'b1000, 4'b0010, 4'b1000};
    logic [1:0] id_v [3] = '{2'd3, 2'd1, 2'd3};
    apply_reset();
    set_op(1, 8'h00, 8'h00, 1'b0);
    set_op(2, 8'h00, 8'h00, 1'b0);
    set_op(3, 8'h00, 8'h00, 1'b0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (bus.req_ready !== g_v[k]) begin
        $display("FAIL wrap_grant[%0d]: req_ready=%b expected %b", k, bus.req_ready, g_v[k]); fails++;
      end
      tick();
      tests++;
      if (bus.rsp_id !== id_v[k]) begin
        $display("FAIL wrap_id[%0d]: id=%0d expected %0d", k, bus.rsp_id, id_v[k]); fails++;
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_reset_hold();
    apply_reset();
    set_op(0, 8'h22, 8'h11, 1'b0);
    bus.req_valid = 4'b0001;
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      $display("FAIL rsthold_no_grant: req_ready=%b expected 0000", bus.req_ready); fails++;
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_flag !== 3'b000 || bus.req_ready !== 4'b0000) begin
      $display("FAIL rsthold_cleared: valid=%b flag=%b req_ready=%b expected 0/000/0000",
               bus.rsp_valid, bus.rsp_flag, bus.req_ready); fails++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001) begin
      $display("FAIL rsthold_regrant: req_ready=%b expected 0001", bus.req_ready); fails++;
    end
    tick();
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_flag !== 3'b010) begin
      $display("FAIL rsthold_rsp: valid=%b id=%0d flag=%b expected 1/0/010",
               bus.rsp_valid, bus.rsp_id, bus.rsp_flag); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one 8-bit magnitude comparator among NREQ requesters.
- Each requester presents an operand pair and a signed/unsigned mode bit. A round-robin arbiter grants one requester per accept cycle.
- The block registers the 3-bit compare result and returns it with the requester ID over a valid/ready response channel.
- Sits between the operator-level compare datapath and the multiple control units (sort, limit-check) that need it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ), minimum 1.
- W, 8, operand width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*W  operand A, requester i at bits [i*W +: W].
- req_b  input  NREQ*W  operand B, same packing as req_a.
- req_signed  input  NREQ  1 = two's-complement compare, 0 = unsigned.
- req_ready  output  NREQ  one-hot grant; a request transfers when req_valid[i] & req_ready[i].
- rsp_valid  output  1  response held valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the granted requester.
- rsp_flag  output  3  [0]=A==B, [1]=A>B, [2]=A<B; exactly one bit set.

Behaviour:
- Reset: state=IDLE; rsp_valid=0, rsp_id=0, rsp_flag=3'b000, req_ready=0, rr_ptr=0.
- FSM states:
  - IDLE: no response held.
  - HOLD: rsp_valid=1; response registers frozen.
- accept condition = (state==IDLE) | (state==HOLD & rsp_ready).
- req_ready is combinational. It is the one-hot round-robin pick among req_valid, searching from rr_ptr upward with wrap. It is gated by accept condition and is 0 when no request is valid.
- On an accept with any req_valid:
  - Latch the granted index into rsp_id and the comparator result into rsp_flag.
  - Set rsp_valid=1 and go to HOLD.
  - Set rr_ptr = grant_index+1, wrapping to 0 after NREQ-1.
- HOLD & rsp_ready & no req_valid: go to IDLE, rsp_valid=0; rsp_id/rsp_flag keep their values.
- HOLD & !rsp_ready: hold all response outputs stable; req_ready=0.
- Latency: grant cycle N produces rsp_valid=1 at cycle N+1.
- Throughput: one compare per cycle when rsp_ready is held high (back-to-back HOLD→HOLD).
- Compare rules:
  - Unsigned mode: plain magnitude compare.
  - Signed mode: operands are two's complement, MSB is the sign. Negative < positive; same-sign pairs compare by magnitude of the full word.
- Fairness: a continuously asserted requester is granted within NREQ accepts.
- rr_ptr advances only on a grant, never on idle cycles.
- Simultaneous rsp_ready and new request in HOLD: the old response retires and the new one loads in the same edge; there is no bubble.
- Requesters must hold req_a/req_b/req_signed stable while req_valid=1 and not granted. A requester may drop req_valid before grant without harm.
- Reset mid-operation: a held response is discarded; no grant is issued in the reset cycle.

Decomposition:
- Package cmp_pkg holds:
  - FLAG_EQ=0, FLAG_GT=1, FLAG_LT=2 bit indices;
  - the state encoding IDLE=1'b0, HOLD=1'b1;
  - a 3-bit flag typedef.
- Sub-module cmp_core: purely combinational, inputs (a, b, is_signed), output flag[2:0]. It is instantiated once, fed by the granted requester's mux.
- Round-robin pick is in-line (priority rotate) in cmp_arbiter.

Test Plan:
- Single request, unsigned: req0 a=8'h05 b=8'h09 → req_ready=4'b0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_flag=3'b100.
- Signed vs unsigned: req1 a=8'hFF b=8'h01, signed=1 → rsp_flag=3'b100; same operands signed=0 → rsp_flag=3'b010; a=b=8'h80 → 3'b001.
- Round-robin: all four valid continuously, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence matches with no idle cycles.
- Backpressure: rsp_ready=0 for 3 cycles after a response → rsp_valid/rsp_id/rsp_flag unchanged and req_ready=0. Raising rsp_ready with req2 valid retires the response and grants req2 on the same edge.
- Wrap and skip: rr_ptr=3, only req1 and req3 valid → grant req3, then req1, then req3.
- Reset in HOLD: rst=1 one cycle while rsp_valid=1 → next cycle rsp_valid=0, rsp_flag=0, req_ready=0. With req0 valid, the grant reappears the cycle after rst falls.
